// File: rtl/ttm_tape_if.sv
`default_nettype none
// ============================================================================
//  Module   : ttm_tape_if
//  Brief    : Core/host-facing signal bundle of the Turing machine tape store.
//  Revision : 1.0
// ============================================================================
interface ttm_tape_if #(
    parameter int ADDR_W = 4,
    parameter int SYM_W  = 2
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [SYM_W-1:0]  cmd_sym;
    logic [1:0]        cmd_move;
    logic [SYM_W-1:0]  rd_sym;
    logic [ADDR_W-1:0] head_pos;
    logic              wrapped;
    logic              load_en;
    logic [ADDR_W-1:0] load_addr;
    logic [SYM_W-1:0]  load_sym;
    logic              clr_start;
    logic [ADDR_W-1:0] scan_addr;
    logic [SYM_W-1:0]  scan_sym;

    modport master (
        output cmd_valid, cmd_write, cmd_sym, cmd_move,
        output load_en, load_addr, load_sym, clr_start, scan_addr,
        input  cmd_ready, rd_sym, head_pos, wrapped, scan_sym
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_sym, cmd_move,
        input  load_en, load_addr, load_sym, clr_start, scan_addr,
        output cmd_ready, rd_sym, head_pos, wrapped, scan_sym
    );
endinterface
`default_nettype wire

// File: rtl/ttm_tape.sv
`default_nettype none
// ============================================================================
//  Module   : ttm_tape
//  Brief    : Tape store and head for the tiny Turing machine core.
//  Revision : 1.0
// ============================================================================
module ttm_tape #(
    parameter int TAPE_LEN = 16,
    parameter int ADDR_W   = 4,
    parameter int SYM_W    = 2
) (
    input  logic       clk,
    input  logic       rst,
    ttm_tape_if.slave  bus
);

    localparam logic [ADDR_W-1:0] c_last = ADDR_W'(TAPE_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EXEC   = 2'd1,
        S_SETTLE = 2'd2,
        S_CLEAR  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic              w_cmd_ready;

    logic [SYM_W-1:0]  r_cells [TAPE_LEN];
    logic [ADDR_W-1:0] r_head;
    logic [ADDR_W-1:0] w_head_next;
    logic              w_wrap;
    logic              r_wrapped;
    logic [SYM_W-1:0]  r_rd_sym;
    logic [ADDR_W-1:0] r_clr_cnt;

    logic              r_cmd_write;
    logic [SYM_W-1:0]  r_cmd_sym;
    logic [1:0]        r_cmd_move;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cmd_ready  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    w_state_next = S_EXEC;
                end else if (bus.clr_start) begin
                    w_state_next = S_CLEAR;
                end
            end
            S_EXEC:   w_state_next = S_SETTLE;
            S_SETTLE: w_state_next = S_IDLE;
            S_CLEAR: begin
                if (r_clr_cnt == c_last) begin
                    w_state_next = S_SETTLE;
                end
            end
            default:  w_state_next = S_IDLE;
        endcase
    end

    // Head arithmetic wraps naturally in ADDR_W bits; edge crossings raise the sticky flag.
    always_comb begin
        w_head_next = r_head;
        w_wrap      = 1'b0;
        case (r_cmd_move)
            2'b01: begin
                w_head_next = r_head - ADDR_W'(1);
                w_wrap      = (r_head == '0);
            end
            2'b10: begin
                w_head_next = r_head + ADDR_W'(1);
                w_wrap      = (r_head == c_last);
            end
            default: begin
                w_head_next = r_head;
                w_wrap      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < TAPE_LEN; i++) begin
                r_cells[i] <= '0;
            end
            r_head      <= '0;
            r_wrapped   <= 1'b0;
            r_rd_sym    <= '0;
            r_clr_cnt   <= '0;
            r_cmd_write <= 1'b0;
            r_cmd_sym   <= '0;
            r_cmd_move  <= 2'b00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Continuous refresh makes a preload under the head visible one edge later.
                    r_rd_sym <= r_cells[r_head];
                    if (bus.cmd_valid) begin
                        r_cmd_write <= bus.cmd_write;
                        r_cmd_sym   <= bus.cmd_sym;
                        r_cmd_move  <= bus.cmd_move;
                    end else if (bus.clr_start) begin
                        r_clr_cnt <= '0;
                    end else if (bus.load_en) begin
                        r_cells[bus.load_addr] <= bus.load_sym;
                    end
                end
                S_EXEC: begin
                    if (r_cmd_write) begin
                        r_cells[r_head] <= r_cmd_sym;
                    end
                    r_head <= w_head_next;
                    if (w_wrap) begin
                        r_wrapped <= 1'b1;
                    end
                end
                S_SETTLE: begin
                    r_rd_sym <= r_cells[r_head];
                end
                S_CLEAR: begin
                    r_cells[r_clr_cnt] <= '0;
                    r_clr_cnt          <= r_clr_cnt + ADDR_W'(1);
                    if (r_clr_cnt == c_last) begin
                        r_wrapped <= 1'b0;
                    end
                end
                default: begin
                    r_rd_sym <= r_rd_sym;
                end
            endcase
        end
    end

    assign bus.cmd_ready = w_cmd_ready;
    assign bus.rd_sym    = r_rd_sym;
    assign bus.head_pos  = r_head;
    assign bus.wrapped   = r_wrapped;
    assign bus.scan_sym  = r_cells[bus.scan_addr];

endmodule
`default_nettype wire

// File: tb/tb_ttm_tape.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ttm_tape
//  Brief    : Directed-vector bench for the Turing machine tape store.
//  Revision : 1.0
// ============================================================================
module tb_ttm_tape;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_fail;

    ttm_tape_if #(.ADDR_W(4), .SYM_W(2)) bus ();

    ttm_tape #(.TAPE_LEN(16), .ADDR_W(4), .SYM_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       w;
        logic [1:0] sym;
        logic [1:0] move;
        logic [3:0] e_head;
        logic [1:0] e_rd;
        logic       e_wr;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called at a negedge with the tape idle; returns at the negedge where ready is back.
    task automatic issue_cmd(input logic w, input logic [1:0] s, input logic [1:0] m,
                             output int low_cycles);
        int n;
        n = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = w;
        bus.cmd_sym   = s;
        bus.cmd_move  = m;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        while (!bus.cmd_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        low_cycles = n;
    endtask

    task automatic load_cell(input logic [3:0] a, input logic [1:0] s);
        bus.load_en   = 1'b1;
        bus.load_addr = a;
        bus.load_sym  = s;
        @(negedge clk);
        bus.load_en   = 1'b0;
    endtask

    task automatic scan_all(input string name, input logic [1:0] exp);
        for (int a = 0; a < 16; a++) begin
            bus.scan_addr = 4'(a);
            #1;
            chk($sformatf("%s[%0d]", name, a), int'(bus.scan_sym), int'(exp));
        end
    endtask

    task automatic scan_one(input string name, input logic [3:0] a, input logic [1:0] exp);
        bus.scan_addr = a;
        #1;
        chk(name, int'(bus.scan_sym), int'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int low;
        n_vec  = 0;
        n_fail = 0;

        vecs[0]  = '{1'b0, 2'd0, 2'b10, 4'd1,  2'd0, 1'b0};
        vecs[1]  = '{1'b0, 2'd0, 2'b10, 4'd2,  2'd0, 1'b0};
        vecs[2]  = '{1'b0, 2'd0, 2'b10, 4'd3,  2'd2, 1'b0};
        vecs[3]  = '{1'b1, 2'd1, 2'b01, 4'd2,  2'd0, 1'b0};
        vecs[4]  = '{1'b0, 2'd0, 2'b01, 4'd1,  2'd0, 1'b0};
        vecs[5]  = '{1'b0, 2'd0, 2'b01, 4'd0,  2'd0, 1'b0};
        vecs[6]  = '{1'b1, 2'd3, 2'b01, 4'd15, 2'd0, 1'b1};
        vecs[7]  = '{1'b0, 2'd0, 2'b10, 4'd0,  2'd3, 1'b1};
        vecs[8]  = '{1'b0, 2'd2, 2'b11, 4'd0,  2'd3, 1'b1};
        vecs[9]  = '{1'b1, 2'd2, 2'b00, 4'd0,  2'd2, 1'b1};
        vecs[10] = '{1'b1, 2'd1, 2'b10, 4'd1,  2'd0, 1'b1};

        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_sym   = 2'd0;
        bus.cmd_move  = 2'b00;
        bus.load_en   = 1'b0;
        bus.load_addr = 4'd0;
        bus.load_sym  = 2'd0;
        bus.clr_start = 1'b0;
        bus.scan_addr = 4'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        chk("reset head_pos",  int'(bus.head_pos),  0);
        chk("reset rd_sym",    int'(bus.rd_sym),    0);
        chk("reset cmd_ready", int'(bus.cmd_ready), 1);
        chk("reset wrapped",   int'(bus.wrapped),   0);
        scan_all("reset scan", 2'd0);

        @(negedge clk);
        load_cell(4'd3, 2'd2);
        scan_one("preload cell3", 4'd3, 2'd2);
        @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            issue_cmd(vecs[i].w, vecs[i].sym, vecs[i].move, low);
            chk($sformatf("vec%0d ready_low", i), low, 2);
            chk($sformatf("vec%0d head_pos", i), int'(bus.head_pos), int'(vecs[i].e_head));
            chk($sformatf("vec%0d rd_sym", i),   int'(bus.rd_sym),   int'(vecs[i].e_rd));
            chk($sformatf("vec%0d wrapped", i),  int'(bus.wrapped),  int'(vecs[i].e_wr));
        end
        scan_one("cell0 after cmds",  4'd0,  2'd1);
        scan_one("cell3 after cmds",  4'd3,  2'd1);
        scan_one("cell15 after cmds", 4'd15, 2'd0);

        // Fill with 1s, then clear while a command is already pending.
        @(negedge clk);
        for (int a = 0; a < 16; a++) load_cell(4'(a), 2'd1);
        @(negedge clk);
        chk("pre-clear rd_sym",  int'(bus.rd_sym),  1);
        chk("pre-clear wrapped", int'(bus.wrapped), 1);
        bus.clr_start = 1'b1;
        @(negedge clk);
        bus.clr_start = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_move  = 2'b10;
        low = 0;
        while (!bus.cmd_ready && low < 60) begin
            low++;
            @(negedge clk);
        end
        chk("clear ready_low",  low, 17);
        chk("clear head_pos",   int'(bus.head_pos), 1);
        chk("clear wrapped",    int'(bus.wrapped),  0);
        chk("clear rd_sym",     int'(bus.rd_sym),   0);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        low = 0;
        while (!bus.cmd_ready && low < 50) begin
            low++;
            @(negedge clk);
        end
        chk("post-clear cmd ready_low", low, 2);
        chk("post-clear cmd head_pos",  int'(bus.head_pos), 2);
        scan_all("cleared scan", 2'd0);

        // Reset in the middle of a clear.
        @(negedge clk);
        for (int a = 0; a < 16; a++) load_cell(4'(a), 2'd1);
        bus.clr_start = 1'b1;
        @(negedge clk);
        bus.clr_start = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid-clear busy", int'(bus.cmd_ready), 0);
        rst = 1'b1;
        #1;
        chk("clr-rst head_pos",  int'(bus.head_pos),  0);
        chk("clr-rst cmd_ready", int'(bus.cmd_ready), 1);
        chk("clr-rst wrapped",   int'(bus.wrapped),   0);
        chk("clr-rst rd_sym",    int'(bus.rd_sym),    0);
        @(negedge clk);
        rst = 1'b0;
        scan_all("clr-rst scan", 2'd0);

        // Reset while a write sits in EXEC.
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_sym   = 2'd3;
        bus.cmd_move  = 2'b10;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        chk("exec busy", int'(bus.cmd_ready), 0);
        scan_one("exec pre-write cell0", 4'd0, 2'd0);
        rst = 1'b1;
        #1;
        chk("exec-rst head_pos",  int'(bus.head_pos),  0);
        chk("exec-rst cmd_ready", int'(bus.cmd_ready), 1);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        scan_one("exec-rst cell0", 4'd0, 2'd0);
        chk("exec-rst head after", int'(bus.head_pos), 0);
        chk("exec-rst rd_sym",     int'(bus.rd_sym),   0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
